// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin arbiter sharing one downstream resource among
// N requesters. Grant is registered and one-hot; a maximum hold time forces
// rotation when other requesters are waiting.
// Optional build macro: RR_ARB_LOCK_EN adds a 'lock' input that suppresses
// timeout preemption while the current owner keeps requesting.
module rr_arbiter_ctrl #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
`ifdef RR_ARB_LOCK_EN
   input  logic           lock,
`endif
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           busy
);

   // Hold counter only needs to reach MAX_HOLD-1.
   localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           state_r;
   logic [N-1:0]     gnt_r;
   logic             gnt_valid_r;
   logic [IDW-1:0]   gnt_id_r;
   logic             busy_r;
   logic [IDW-1:0]   ptr_r;
   logic [HCW-1:0]   hold_cnt_r;

   logic             lock_s;
   logic [IDW-1:0]   nxt_owner_s;
   logic [IDW-1:0]   base_s;
   logic [N-1:0]     vec_s;
   logic             found_s;
   logic [IDW-1:0]   win_id_s;
   logic [N-1:0]     win_gnt_s;
   int               best_s;
   int               dist_s;
   logic             owner_req_s;
   logic             others_s;
   logic             hold_max_s;
   logic             release_s;
   logic             timeout_s;

`ifdef RR_ARB_LOCK_EN
   assign lock_s = lock;
`else
   assign lock_s = 1'b0;
`endif

   // Successor of the current owner, wrapping N-1 back to 0 by explicit compare.
   always_comb begin
      nxt_owner_s = '0;
      if (gnt_id_r == IDW'(N - 1)) begin
         nxt_owner_s = '0;
      end else begin
         nxt_owner_s = gnt_id_r + IDW'(1);
      end
   end

   // Pick the search start and candidate set: full request vector from ptr when
   // idle, or the non-owner requests starting just after the owner when granted.
   always_comb begin
      base_s = ptr_r;
      vec_s  = req;
      if (state_r == ST_GRANT) begin
         base_s = nxt_owner_s;
         vec_s  = req & ~gnt_r;
      end else begin
         base_s = ptr_r;
         vec_s  = req;
      end
   end

   // Circular priority search: the set bit closest (going upward) to base_s wins.
   always_comb begin
      found_s   = 1'b0;
      win_id_s  = '0;
      win_gnt_s = '0;
      best_s    = N;
      dist_s    = 0;
      for (int i = 0; i < N; i++) begin
         if (i >= int'(base_s)) begin
            dist_s = i - int'(base_s);
         end else begin
            dist_s = i + N - int'(base_s);
         end
         if (vec_s[i] && (dist_s < best_s)) begin
            best_s       = dist_s;
            found_s      = 1'b1;
            win_id_s     = IDW'(i);
            win_gnt_s    = '0;
            win_gnt_s[i] = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

   // Decode release and timeout conditions for the current owner.
   always_comb begin
      owner_req_s = |(req & gnt_r);
      others_s    = |(req & ~gnt_r);
      hold_max_s  = (hold_cnt_r == HCW'(MAX_HOLD - 1));
      release_s   = 1'b0;
      timeout_s   = 1'b0;
      if (state_r == ST_GRANT) begin
         release_s = ~owner_req_s;
         timeout_s = owner_req_s & hold_max_s & others_s & ~lock_s;
      end else begin
         release_s = 1'b0;
         timeout_s = 1'b0;
      end
   end

   // Arbiter FSM with registered grant, owner index, pointer and hold counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         gnt_r       <= '0;
         gnt_valid_r <= 1'b0;
         gnt_id_r    <= '0;
         busy_r      <= 1'b0;
         ptr_r       <= '0;
         hold_cnt_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  gnt_r       <= win_gnt_s;
                  gnt_id_r    <= win_id_s;
                  gnt_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
                  hold_cnt_r  <= '0;
                  state_r     <= ST_GRANT;
               end else begin
                  gnt_r       <= '0;
                  gnt_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (release_s || timeout_s) begin
                  // Ownership moves on; the old owner goes to the back of the ring.
                  ptr_r      <= nxt_owner_s;
                  hold_cnt_r <= '0;
                  if (found_s) begin
                     gnt_r       <= win_gnt_s;
                     gnt_id_r    <= win_id_s;
                     gnt_valid_r <= 1'b1;
                     busy_r      <= 1'b1;
                     state_r     <= ST_GRANT;
                  end else begin
                     gnt_r       <= '0;
                     gnt_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                     state_r     <= ST_IDLE;
                  end
               end else begin
                  // Keep the grant; counter saturates so a lone owner never wraps.
                  if (hold_max_s) begin
                     hold_cnt_r <= hold_cnt_r;
                  end else begin
                     hold_cnt_r <= hold_cnt_r + HCW'(1);
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               gnt_r       <= '0;
               gnt_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               hold_cnt_r  <= '0;
            end
         endcase
      end
   end

   assign gnt       = gnt_r;
   assign gnt_valid = gnt_valid_r;
   assign gnt_id    = gnt_id_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Scoreboard bench for rr_arbiter_ctrl (N=4, MAX_HOLD=4). The driver applies
// directed vectors on the falling edge and queues the hand-computed outputs
// expected after the following rising edge; a monitor pops and compares.
module tb_rr_arbiter_ctrl;

   localparam int N        = 4;
   localparam int MAX_HOLD = 4;
   localparam int IDW      = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic           busy;
`ifdef RR_ARB_LOCK_EN
   logic           lock;
`endif

   typedef struct packed {
      logic [N-1:0]   gnt;
      logic [IDW-1:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   vec_no   = 0;

   always #5 clk = ~clk;

   rr_arbiter_ctrl #(
      .N(N),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef RR_ARB_LOCK_EN
      .lock(lock),
`endif
      .req(req),
      .gnt(gnt),
      .gnt_valid(gnt_valid),
      .gnt_id(gnt_id),
      .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s vec=%0d: actual=%0h required=%0h", name, vec_no, act, want);
      end
   endtask

   // Monitor: after every rising edge, compare outputs against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec_no++;
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("gnt_id", 32'(gnt_id), 32'(e.id));
            check("gnt_valid", 32'(gnt_valid), 32'(|e.gnt));
            check("busy", 32'(busy), 32'(|e.gnt));
         end
      end
   end

   // Driver: apply inputs on the falling edge and queue the expected result.
   task automatic step(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] eg, input logic [IDW-1:0] eid);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = rq;
      e.gnt = eg;
      e.id  = eid;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
`ifdef RR_ARB_LOCK_EN
      lock = 1'b0;
`endif

      // Reset then idle
      step(1'b1, 4'b0000, 4'b0000, 2'd0);
      step(1'b1, 4'b0000, 4'b0000, 2'd0);
      for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 2'd0);

      // Single request latency, release, pointer advance to 3
      step(1'b0, 4'b0100, 4'b0100, 2'd2);
      step(1'b0, 4'b0100, 4'b0100, 2'd2);
      step(1'b0, 4'b0100, 4'b0100, 2'd2);
      step(1'b0, 4'b0000, 4'b0000, 2'd2);
      step(1'b0, 4'b1001, 4'b1000, 2'd3);   // search starts at 3
      step(1'b0, 4'b0000, 4'b0000, 2'd3);   // ptr wraps 3 -> 0

      // Round-robin rotation with back-to-back handoff
      step(1'b0, 4'b1111, 4'b0001, 2'd0);
      step(1'b0, 4'b1110, 4'b0010, 2'd1);
      step(1'b0, 4'b1101, 4'b0100, 2'd2);
      step(1'b0, 4'b1011, 4'b1000, 2'd3);
      step(1'b0, 4'b0111, 4'b0001, 2'd0);
      step(1'b0, 4'b0000, 4'b0000, 2'd0);   // ptr now 1

      // Timeout preemption from a clean reset (ptr=0)
      step(1'b1, 4'b0000, 4'b0000, 2'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 4'b0010, 2'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0);
      // Lone requester: no preemption
      for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0);
      step(1'b0, 4'b0000, 4'b0000, 2'd0);   // ptr now 1

      // Simultaneous release and new request
      step(1'b0, 4'b0010, 4'b0010, 2'd1);
      step(1'b0, 4'b0010, 4'b0010, 2'd1);
      step(1'b0, 4'b1000, 4'b1000, 2'd3);
      step(1'b0, 4'b0000, 4'b0000, 2'd3);   // ptr now 0

      // Reset mid-grant; the first grant afterwards searches from 0
      step(1'b0, 4'b0100, 4'b0100, 2'd2);
      step(1'b0, 4'b0000, 4'b0000, 2'd2);   // ptr now 3
      step(1'b0, 4'b0100, 4'b0100, 2'd2);
      step(1'b0, 4'b0100, 4'b0100, 2'd2);
      step(1'b1, 4'b0100, 4'b0000, 2'd0);
      step(1'b0, 4'b1001, 4'b0001, 2'd0);
      step(1'b0, 4'b0000, 4'b0000, 2'd0);

`ifdef RR_ARB_LOCK_EN
      // Locked owner is never preempted
      step(1'b1, 4'b0000, 4'b0000, 2'd0);
      @(negedge clk);
      lock = 1'b1;
      for (int i = 0; i < 25; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0);
      step(1'b0, 4'b0010, 4'b0010, 2'd1);   // release still ends the grant
      @(negedge clk);
      lock = 1'b0;
`endif

      // Drain the scoreboard with a bounded wait
      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
